// File: rtl/sdrxframe8x_if.sv
// Byte-stream and control bundle between the SD data engine and the 8x receive framer.
// The framer takes the slave side; the engine (or a bench) drives the master side.
interface sdrxframe8x_if #(
    parameter int LGLEN = 10
);
    logic             i_en;
    logic [LGLEN-1:0] i_len;
    logic [7:0]       i_sample;
    logic [7:0]       i_wide;
    logic             o_valid;
    logic [7:0]       o_data;
    logic             o_done;
    logic             o_crc_err;
    logic             o_timeout;
    logic             o_busy;

    modport slave (
        input  i_en, i_len, i_sample, i_wide,
        output o_valid, o_data, o_done, o_crc_err, o_timeout, o_busy
    );

    modport master (
        output i_en, i_len, i_sample, i_wide,
        input  o_valid, o_data, o_done, o_crc_err, o_timeout, o_busy
    );
endinterface

// File: rtl/sdrxframe8x.sv
// Receive framer for one SD line behind the 8x oversampling SERDES: start-bit hunt,
// MSB-first byte assembly, CRC16-CCITT residue check and stop-bit check.
module sdrxframe8x #(
    parameter int LGLEN     = 10,
    parameter int LGTIMEOUT = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    sdrxframe8x_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        DATA,
        CRC,
        STOP,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LGLEN-1:0]     len_q, len_d;
    logic [LGLEN-1:0]     byteCnt_q, byteCnt_d;
    logic [3:0]           bitCnt_q, bitCnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [15:0]          crc_q, crc_d;
    logic [LGTIMEOUT-1:0] timer_q, timer_d;
    logic                 enPrev_q;
    logic                 valid_q, valid_d;
    logic [7:0]           data_q, data_d;
    logic                 done_q, done_d;
    logic                 crcErr_q, crcErr_d;
    logic                 timeout_q, timeout_d;
    logic                 bitVal;

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            byteCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            timer_q   <= '0;
            enPrev_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            crcErr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            byteCnt_q <= byteCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            timer_q   <= timer_d;
            enPrev_q  <= bus.i_en;
            valid_q   <= valid_d;
            data_q    <= data_d;
            done_q    <= done_d;
            crcErr_q  <= crcErr_d;
            timeout_q <= timeout_d;
        end
    end

    // Flagged slots are walked oldest-first; state_d is updated in place so a
    // transition mid-word hands the remaining slots to the new state.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        byteCnt_d = byteCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        timer_d   = timer_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        done_d    = 1'b0;
        crcErr_d  = 1'b0;
        timeout_d = 1'b0;
        bitVal    = 1'b0;

        if (!bus.i_en) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (!enPrev_q) begin
                state_d   = HUNT;
                len_d     = bus.i_len;
                crc_d     = '0;
                timer_d   = '0;
                bitCnt_d  = '0;
                byteCnt_d = '0;
                shift_d   = '0;
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (bus.i_sample[k]) begin
                    bitVal = bus.i_wide[k];
                    case (state_d)
                        HUNT: begin
                            if (!bitVal) begin
                                state_d   = (len_q == '0) ? CRC : DATA;
                                bitCnt_d  = '0;
                                byteCnt_d = '0;
                            end
                        end
                        DATA: begin
                            shift_d = {shift_d[6:0], bitVal};
                            crc_d   = crcStep(crc_d, bitVal);
                            if (bitCnt_d == 4'd7) begin
                                bitCnt_d = '0;
                                valid_d  = 1'b1;
                                data_d   = shift_d;
                                if (byteCnt_d == len_q - 1'b1) begin
                                    state_d = CRC;
                                end else begin
                                    byteCnt_d = byteCnt_d + 1'b1;
                                end
                            end else begin
                                bitCnt_d = bitCnt_d + 4'd1;
                            end
                        end
                        CRC: begin
                            crc_d = crcStep(crc_d, bitVal);
                            if (bitCnt_d == 4'd15) begin
                                bitCnt_d = '0;
                                state_d  = STOP;
                            end else begin
                                bitCnt_d = bitCnt_d + 4'd1;
                            end
                        end
                        STOP: begin
                            done_d   = 1'b1;
                            crcErr_d = (crc_d != 16'h0000) | ~bitVal;
                            state_d  = DONE;
                        end
                        default: ;
                    endcase
                end
            end

            // Timeout is forfeited if a start bit showed up anywhere in this word.
            if (state_q == HUNT) begin
                timer_d = timer_q + 1'b1;
                if ((&timer_d) && (state_d == HUNT)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_data    = data_q;
    assign bus.o_done    = done_q;
    assign bus.o_crc_err = crcErr_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sdrxframe8x.sv
// Self-checking bench for sdrxframe8x: table of whole frames plus directed
// timeout, abort/re-arm and mid-frame reset sequences.
module tb_sdrxframe8x;

    localparam int LGLEN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sdrxframe8x_if #(.LGLEN(LGLEN)) bus ();

    sdrxframe8x #(
        .LGLEN    (LGLEN),
        .LGTIMEOUT(4)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    typedef struct {
        string           tag;
        int              len;
        logic [0:3][7:0] bytes;
        logic [7:0]      sample;
        int              flipBit;
        logic            stopBit;
        logic            expErr;
    } frameVec_t;

    frameVec_t  vecs[6];

    int         checkCount = 0;
    int         errorCount = 0;
    int         cycleNo = 0;
    logic [7:0] gotBytes[$];
    int         doneCount;
    int         toCount;
    int         lastValidCycle;
    int         doneCycle;
    logic       gotErr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, then record any output pulses.
    task automatic applyStimulus(input logic en, input logic [LGLEN-1:0] len,
                                 input logic [7:0] sample, input logic [7:0] wide);
        bus.i_en     = en;
        bus.i_len    = len;
        bus.i_sample = sample;
        bus.i_wide   = wide;
        @(posedge clk);
        #1;
        cycleNo++;
        if (bus.o_valid === 1'b1) begin
            gotBytes.push_back(bus.o_data);
            lastValidCycle = cycleNo;
        end
        if (bus.o_done === 1'b1) begin
            doneCount++;
            gotErr    = bus.o_crc_err;
            doneCycle = cycleNo;
        end
        if (bus.o_timeout === 1'b1) toCount++;
    endtask

    task automatic clearRecord();
        gotBytes.delete();
        doneCount      = 0;
        toCount        = 0;
        lastValidCycle = 0;
        doneCycle      = 0;
        gotErr         = 1'b0;
    endtask

    // Reference CRC16-CCITT (init 0) over the frame's data bytes, MSB first.
    function automatic logic [15:0] crcModel(input frameVec_t v);
        logic [15:0] c = 16'h0000;
        logic        fb;
        for (int i = 0; i < v.len; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ v.bytes[i][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic serialize(input logic [7:0] sample, inout logic bits[$]);
        logic [7:0] wide;
        while (bits.size() > 0) begin
            wide = 8'($urandom);
            for (int k = 7; k >= 0; k--)
                if (sample[k]) wide[k] = (bits.size() > 0) ? bits.pop_front() : 1'b1;
            applyStimulus(1'b1, LGLEN'(7), sample, wide);
        end
    endtask

    task automatic runFrame(input frameVec_t v);
        logic        bits[$];
        logic [15:0] crc;
        int          idleBits;
        int          nCmp;
        clearRecord();
        applyStimulus(1'b0, '0, 8'h00, 8'hFF);
        applyStimulus(1'b0, '0, 8'h00, 8'hFF);
        applyStimulus(1'b1, LGLEN'(v.len), 8'h00, 8'hFF);
        idleBits = (v.sample == 8'h88) ? 2 : 3;
        repeat (idleBits) bits.push_back(1'b1);
        bits.push_back(1'b0);
        for (int i = 0; i < v.len; i++)
            for (int j = 7; j >= 0; j--) bits.push_back(v.bytes[i][j]);
        crc = crcModel(v);
        if (v.flipBit >= 0) crc[v.flipBit] = ~crc[v.flipBit];
        for (int j = 15; j >= 0; j--) bits.push_back(crc[j]);
        bits.push_back(v.stopBit);
        serialize(v.sample, bits);
        repeat (4) applyStimulus(1'b1, LGLEN'(7), v.sample, 8'hFF);
        applyStimulus(1'b0, '0, 8'h00, 8'hFF);

        checkOutput({v.tag, " busy after en drop"}, 32'(bus.o_busy), 32'd0);
        checkOutput({v.tag, " done count"}, doneCount, 1);
        checkOutput({v.tag, " crc_err"}, 32'(gotErr), 32'(v.expErr));
        checkOutput({v.tag, " byte count"}, gotBytes.size(), v.len);
        nCmp = (gotBytes.size() < v.len) ? gotBytes.size() : v.len;
        for (int i = 0; i < nCmp; i++)
            checkOutput($sformatf("%s byte%0d", v.tag, i), 32'(gotBytes[i]), 32'(v.bytes[i]));
        if (v.len > 0)
            checkOutput({v.tag, " valid before done"}, 32'(lastValidCycle < doneCycle), 32'd1);
    endtask

    initial begin
        logic bits[$];

        vecs[0] = '{"t1_1bit",   2, {8'hA5, 8'h3C, 8'h00, 8'h00}, 8'h10, -1, 1'b1, 1'b0};
        vecs[1] = '{"t2_2bit",   2, {8'hA5, 8'h3C, 8'h00, 8'h00}, 8'h88, -1, 1'b1, 1'b0};
        vecs[2] = '{"t3_crcflip",2, {8'hA5, 8'h3C, 8'h00, 8'h00}, 8'h10,  3, 1'b1, 1'b1};
        vecs[3] = '{"t3_stop0",  2, {8'hA5, 8'h3C, 8'h00, 8'h00}, 8'h10, -1, 1'b0, 1'b1};
        vecs[4] = '{"t6_len0",   0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h10, -1, 1'b1, 1'b0};
        vecs[5] = '{"len3_2bit", 3, {8'h00, 8'hFF, 8'h81, 8'h00}, 8'h88, -1, 1'b1, 1'b0};

        clearRecord();
        rst = 1'b1;
        applyStimulus(1'b1, LGLEN'(5), 8'hFF, 8'h00);
        applyStimulus(1'b1, LGLEN'(5), 8'hFF, 8'h00);
        checkOutput("reset valid",   32'(bus.o_valid),   32'd0);
        checkOutput("reset data",    32'(bus.o_data),    32'd0);
        checkOutput("reset done",    32'(bus.o_done),    32'd0);
        checkOutput("reset crc_err", 32'(bus.o_crc_err), 32'd0);
        checkOutput("reset timeout", 32'(bus.o_timeout), 32'd0);
        checkOutput("reset busy",    32'(bus.o_busy),    32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) runFrame(vecs[i]);

        // Line parked high: timeout on the 15th cycle after the arming edge.
        clearRecord();
        applyStimulus(1'b0, '0, 8'h10, 8'hFF);
        applyStimulus(1'b0, '0, 8'h10, 8'hFF);
        applyStimulus(1'b1, LGLEN'(1), 8'h10, 8'hFF);
        checkOutput("t4 busy after arm", 32'(bus.o_busy), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, LGLEN'(1), 8'h10, 8'hFF);
            checkOutput($sformatf("t4 timeout cyc%0d", k), 32'(bus.o_timeout), 32'(k == 15));
            if (k >= 15) checkOutput($sformatf("t4 busy cyc%0d", k), 32'(bus.o_busy), 32'd0);
        end
        checkOutput("t4 timeout count", toCount, 1);

        // Abort a len=4 frame after its first byte, then re-arm.
        clearRecord();
        applyStimulus(1'b0, '0, 8'h10, 8'hFF);
        applyStimulus(1'b0, '0, 8'h10, 8'hFF);
        applyStimulus(1'b1, LGLEN'(4), 8'h10, 8'hFF);
        bits = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        serialize(8'h10, bits);
        applyStimulus(1'b0, LGLEN'(4), 8'h10, 8'h00);
        checkOutput("t5 busy after abort", 32'(bus.o_busy), 32'd0);
        repeat (6) applyStimulus(1'b0, LGLEN'(4), 8'h10, 8'h00);
        checkOutput("t5 done count", doneCount, 0);
        checkOutput("t5 byte count", gotBytes.size(), 1);
        if (gotBytes.size() > 0) checkOutput("t5 byte0", 32'(gotBytes[0]), 32'h11);
        vecs[0].tag = "t5_rearm";
        runFrame(vecs[0]);

        // Reset in the middle of DATA with i_en still high.
        clearRecord();
        applyStimulus(1'b0, '0, 8'h10, 8'hFF);
        applyStimulus(1'b0, '0, 8'h10, 8'hFF);
        applyStimulus(1'b1, LGLEN'(2), 8'h10, 8'hFF);
        bits = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        serialize(8'h10, bits);
        checkOutput("t6 busy before reset", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b1, LGLEN'(2), 8'h10, 8'h00);
        checkOutput("t6 rst valid",   32'(bus.o_valid),   32'd0);
        checkOutput("t6 rst data",    32'(bus.o_data),    32'd0);
        checkOutput("t6 rst done",    32'(bus.o_done),    32'd0);
        checkOutput("t6 rst crc_err", 32'(bus.o_crc_err), 32'd0);
        checkOutput("t6 rst timeout", 32'(bus.o_timeout), 32'd0);
        checkOutput("t6 rst busy",    32'(bus.o_busy),    32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 8'h00, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
